seg_display_ctrl: RTL and testbench

Parametrised 7-segment status display for the core. It shows `pc_i` as hex, paging through all nibbles when `DATA_WIDTH` exceeds the digit count. In error state it shows sticky, blinking error flags. It sits beside the core top, fed by the core's next-state and interrupt vectors. All glyph outputs are registered.

---
 rtl/seg_pkg.sv | 58 +++++
 rtl/seg_display_ctrl_tick_div.sv | 27 ++
 rtl/seg_display_ctrl.sv | 156 +++++++++++++++
 tb/tb_seg_display_ctrl.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/seg_pkg.sv
// Glyph table and shared types for the 7-segment status display.
// Glyphs are active-low, bit7..0 = a,b,c,d,e,f,g,dp.
package seg_pkg;

  localparam logic [7:0] SEG0    = ~8'b1111_1100;
  localparam logic [7:0] SEG1    = ~8'b0110_0000;
  localparam logic [7:0] SEG2    = ~8'b1101_1010;
  localparam logic [7:0] SEG3    = ~8'b1111_0010;
  localparam logic [7:0] SEG4    = ~8'b0110_0110;
  localparam logic [7:0] SEG5    = ~8'b1011_0110;
  localparam logic [7:0] SEG6    = ~8'b1011_1110;
  localparam logic [7:0] SEG7    = ~8'b1110_0000;
  localparam logic [7:0] SEG8    = ~8'b1111_1110;
  localparam logic [7:0] SEG9    = ~8'b1111_0110;
  localparam logic [7:0] SEGA    = ~8'b1110_1110;
  localparam logic [7:0] SEGB    = ~8'b0011_1110;
  localparam logic [7:0] SEGC    = ~8'b1001_1100;
  localparam logic [7:0] SEGD    = ~8'b0111_1010;
  localparam logic [7:0] SEGE    = ~8'b1001_1110;
  localparam logic [7:0] SEGF    = ~8'b1000_1110;
  localparam logic [7:0] SEGNONE = 8'hFF;
  localparam logic [7:0] SEGERR  = ~8'b1001_0010;

  typedef enum logic [2:0] {
    RST    = 3'd0,
    NORMAL = 3'd1,
    HALT   = 3'd2
  } core_state_e;

  typedef enum logic {
    VAL = 1'b0,
    ERR = 1'b1
  } disp_mode_e;

  function automatic logic [7:0] hex2seg(input logic [3:0] n);
    logic [7:0] g;
    unique case (n)
      4'h0: g = SEG0;
      4'h1: g = SEG1;
      4'h2: g = SEG2;
      4'h3: g = SEG3;
      4'h4: g = SEG4;
      4'h5: g = SEG5;
      4'h6: g = SEG6;
      4'h7: g = SEG7;
      4'h8: g = SEG8;
      4'h9: g = SEG9;
      4'hA: g = SEGA;
      4'hB: g = SEGB;
      4'hC: g = SEGC;
      4'hD: g = SEGD;
      4'hE: g = SEGE;
      4'hF: g = SEGF;
    endcase
    return g;
  endfunction

endpackage

// File: rtl/seg_display_ctrl_tick_div.sv
// Free-running divider: counts enabled cycles, pulses on the last one.
// Sync clear wins over enable and suppresses the pulse.
module tick_div #(
  parameter int PERIOD = 4
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic en_i,
  input  logic clr_i,
  output logic tick_o
);

  localparam int CW = (PERIOD > 1) ? $clog2(PERIOD) : 1;

  logic [CW-1:0] cnt_q;

  assign tick_o = en_i && !clr_i && (cnt_q == CW'(PERIOD - 1));

  always_ff @(posedge clk_i) begin
    if (rst_i || clr_i) begin
      cnt_q <= '0;
    end else if (en_i) begin
      cnt_q <= tick_o ? '0 : cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/seg_display_ctrl.sv
// 7-segment status display: paged hex PC or blinking sticky error flags.
// Define DISP_SCAN_EN to add a multiplexed single-digit scan output.
module seg_display_ctrl
  import seg_pkg::*;
#(
  parameter int DATA_WIDTH  = 64,
  parameter int NUM_DIGITS  = 8,
  parameter int NUM_ERR     = 4,
  parameter int PAGE_TICKS  = 50_000_000,
  parameter int BLINK_TICKS = 25_000_000,
`ifdef DISP_SCAN_EN
  parameter int SCAN_TICKS  = 50_000,
`endif
  localparam int NUM_PAGES  =
    (DATA_WIDTH + 4 * NUM_DIGITS - 1) / (4 * NUM_DIGITS),
  localparam int PW = (NUM_PAGES > 1) ? $clog2(NUM_PAGES) : 1
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic [DATA_WIDTH-1:0]      pc_i,
  input  logic [2:0]                 nstate_i,
  input  logic [NUM_ERR-1:0]         interrupts_i,
  input  logic                       err_clr_i,
  input  logic                       page_hold_i,
  output logic [NUM_DIGITS-1:0][7:0] segs_o,
  output logic [PW-1:0]              page_o,
  output logic [NUM_ERR-1:0]         err_o
`ifdef DISP_SCAN_EN
  ,
  output logic [7:0]                 scan_seg_o,
  output logic [NUM_DIGITS-1:0]      scan_an_o
`endif
);

  localparam int NIBS = DATA_WIDTH / 4;
  localparam int PADW = NUM_PAGES * NUM_DIGITS * 4;

  logic [DATA_WIDTH-1:0]      snap_q;
  logic [DATA_WIDTH-1:0]      snap_d;
  logic [PADW-1:0]            snap_pad;
  logic [NUM_ERR-1:0]         err_d;
  logic [NUM_DIGITS-1:0]      err_pad;
  disp_mode_e                 mode_q;
  disp_mode_e                 mode_d;
  logic [PW-1:0]              page_d;
  logic                       blink_q;
  logic                       blink_d;
  logic                       page_tick;
  logic                       blink_tick;
  logic                       err_entry;
  logic                       err_exit;
  logic [NUM_DIGITS-1:0][7:0] segs_d;
  int                         nib;

  assign snap_d   = (nstate_i == NORMAL) ? pc_i : snap_q;
  assign snap_pad = PADW'(snap_d);
  assign err_d    = err_clr_i ? '0 : (err_o | interrupts_i);
  assign err_pad  = NUM_DIGITS'(err_d);

  assign mode_d = (nstate_i == RST || nstate_i == NORMAL ||
                   nstate_i == HALT) ? VAL : ERR;

  assign err_entry = (mode_q == VAL) && (mode_d == ERR);
  assign err_exit  = (mode_q == ERR) && (mode_d == VAL);

  tick_div #(.PERIOD(PAGE_TICKS)) u_page_div (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .en_i   ((nstate_i == NORMAL) && !page_hold_i),
    .clr_i  (err_exit),
    .tick_o (page_tick)
  );

  tick_div #(.PERIOD(BLINK_TICKS)) u_blink_div (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .en_i   (mode_d == ERR),
    .clr_i  (err_entry),
    .tick_o (blink_tick)
  );

  always_comb begin
    page_d = page_o;
    if (err_exit) begin
      page_d = '0;
    end else if (page_tick) begin
      page_d = (page_o == PW'(NUM_PAGES - 1)) ? '0 : page_o + 1'b1;
    end
  end

  assign blink_d = err_entry ? 1'b1 : (blink_tick ? ~blink_q : blink_q);

  // Glyphs are built from next-state values so segs_o lags inputs by one edge.
  always_comb begin
    segs_d = '0;
    nib    = 0;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      segs_d[k] = SEGNONE;
      if (mode_d == ERR) begin
        if (err_pad[k] && blink_d) segs_d[k] = SEGERR;
      end else if (nstate_i != RST) begin
        nib = int'(page_d) * NUM_DIGITS + k;
        if (nib < NIBS) segs_d[k] = hex2seg(snap_pad[nib*4 +: 4]);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      mode_q  <= VAL;
      snap_q  <= '0;
      err_o   <= '0;
      page_o  <= '0;
      blink_q <= 1'b0;
      segs_o  <= {NUM_DIGITS{SEGNONE}};
    end else begin
      mode_q  <= mode_d;
      snap_q  <= snap_d;
      err_o   <= err_d;
      page_o  <= page_d;
      blink_q <= blink_d;
      segs_o  <= segs_d;
    end
  end

`ifdef DISP_SCAN_EN
  localparam int SW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  logic          scan_tick;
  logic [SW-1:0] scan_idx_q;

  tick_div #(.PERIOD(SCAN_TICKS)) u_scan_div (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .en_i   (1'b1),
    .clr_i  (1'b0),
    .tick_o (scan_tick)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      scan_idx_q <= '0;
      scan_an_o  <= '1;
      scan_seg_o <= SEGNONE;
    end else begin
      if (scan_tick) begin
        scan_idx_q <= (scan_idx_q == SW'(NUM_DIGITS - 1)) ?
                      '0 : scan_idx_q + 1'b1;
      end
      scan_an_o  <= ~(NUM_DIGITS'(1) << scan_idx_q);
      scan_seg_o <= segs_o[scan_idx_q];
    end
  end
`endif

endmodule

// File: tb/tb_seg_display_ctrl.sv
// Scoreboard bench for seg_display_ctrl: directed plus randomized stimulus
// against a cycle-count based reference model.
module tb_seg_display_ctrl;

  localparam int DW = 40;
  localparam int ND = 4;
  localparam int NE = 3;
  localparam int PT = 4;
  localparam int BT = 3;
  localparam int NP = (DW + 4 * ND - 1) / (4 * ND);
  localparam int PW = (NP > 1) ? $clog2(NP) : 1;

  typedef struct packed {
    logic [ND-1:0][7:0] segs;
    logic [PW-1:0]      page;
    logic [NE-1:0]      err;
  } exp_t;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic [DW-1:0]      pc = '0;
  logic [2:0]         ns = 3'd0;
  logic [NE-1:0]      intr = '0;
  logic               clr = 1'b0;
  logic               hold = 1'b0;
  logic [ND-1:0][7:0] segs;
  logic [PW-1:0]      page;
  logic [NE-1:0]      err;
`ifdef DISP_SCAN_EN
  logic [7:0]         scan_seg;
  logic [ND-1:0]      scan_an;
`endif

  exp_t q[$];
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  bit   stim_done = 0;

  // reference model state: cycle counts rather than hardware counters
  logic [DW-1:0] m_snap;
  logic [NE-1:0] m_err;
  int            n_page;
  int            n_blink;
  bit            m_in_err;

  always #5 clk = ~clk;

  seg_display_ctrl #(
    .DATA_WIDTH  (DW),
    .NUM_DIGITS  (ND),
    .NUM_ERR     (NE),
    .PAGE_TICKS  (PT),
    .BLINK_TICKS (BT)
  ) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .pc_i         (pc),
    .nstate_i     (ns),
    .interrupts_i (intr),
    .err_clr_i    (clr),
    .page_hold_i  (hold),
    .segs_o       (segs),
    .page_o       (page),
    .err_o        (err)
`ifdef DISP_SCAN_EN
    ,
    .scan_seg_o   (scan_seg),
    .scan_an_o    (scan_an)
`endif
  );

  function automatic logic [7:0] glyph(input logic [3:0] v);
    logic [6:0] on;
    case (v)
      4'h0: on = 7'b1111110;
      4'h1: on = 7'b0110000;
      4'h2: on = 7'b1101101;
      4'h3: on = 7'b1111001;
      4'h4: on = 7'b0110011;
      4'h5: on = 7'b1011011;
      4'h6: on = 7'b1011111;
      4'h7: on = 7'b1110000;
      4'h8: on = 7'b1111111;
      4'h9: on = 7'b1111011;
      4'hA: on = 7'b1110111;
      4'hB: on = 7'b0011111;
      4'hC: on = 7'b1001110;
      4'hD: on = 7'b0111101;
      4'hE: on = 7'b1001111;
      default: on = 7'b1000111;
    endcase
    return ~{on, 1'b0};
  endfunction

  task automatic step(input logic r, input logic [DW-1:0] p,
                      input logic [2:0] s, input logic [NE-1:0] i,
                      input logic c, input logic h);
    exp_t          e;
    bit            now_err;
    bit            blink_on;
    int            pg;
    int            nb;
    logic [DW-1:0] sh;
    @(negedge clk);
    rst = r; pc = p; ns = s; intr = i; clr = c; hold = h;
    e.segs = '1;
    if (r) begin
      m_snap = '0; m_err = '0; n_page = 0; n_blink = 0; m_in_err = 0;
    end else begin
      now_err = (s > 3'd2);
      if (s == 3'd1) m_snap = p;
      m_err = c ? '0 : (m_err | i);
      if (now_err) n_blink = m_in_err ? n_blink + 1 : 0;
      else if (m_in_err) n_page = 0;
      else if (s == 3'd1 && !h) n_page++;
      m_in_err = now_err;
      blink_on = ((n_blink / BT) % 2) == 0;
      pg = (n_page / PT) % NP;
      for (int k = 0; k < ND; k++) begin
        if (now_err) begin
          if (k < NE && m_err[k] && blink_on) e.segs[k] = 8'h6D;
        end else if (s != 3'd0) begin
          nb = pg * ND + k;
          if (nb < DW / 4) begin
            sh = m_snap >> (4 * nb);
            e.segs[k] = glyph(sh[3:0]);
          end
        end
      end
    end
    e.page = PW'((n_page / PT) % NP);
    e.err  = m_err;
    q.push_back(e);
  endtask

  task automatic monitor();
    exp_t e;
    for (int c = 0; c < 20000; c++) begin
      @(posedge clk);
      #2;
      if (q.size() == 0) begin
        if (stim_done) return;
      end else begin
        e = q.pop_front();
        cyc++;
        checks++;
        if (segs !== e.segs) begin
          failures++;
          $display("FAIL segs cyc=%0d got=%h exp=%h", cyc, segs, e.segs);
        end
        checks++;
        if (page !== e.page) begin
          failures++;
          $display("FAIL page cyc=%0d got=%0d exp=%0d", cyc, page, e.page);
        end
        checks++;
        if (err !== e.err) begin
          failures++;
          $display("FAIL err cyc=%0d got=%b exp=%b", cyc, err, e.err);
        end
      end
    end
    failures++;
    $display("FAIL timeout monitor got=%0d pending exp=0", q.size());
  endtask

  task automatic stimulus();
    logic [2:0]    s;
    int            len;
    int            pick;
    logic [DW-1:0] p;
    p = 40'h67_89AB_CDEF;
    step(1, '0, 3'd1, '0, 0, 0);
    step(1, '0, 3'd1, '0, 0, 0);
    repeat (14) step(0, p, 3'd1, '0, 0, 0);
    repeat (20) step(0, 40'hDEAD, 3'd2, '0, 0, 0);
    repeat (6) step(0, 40'h12_3456_789A, 3'd1, '0, 0, 1);
    repeat (5) step(0, 40'h12_3456_789A, 3'd1, '0, 0, 0);
    step(0, '0, 3'd3, 3'b101, 0, 0);
    repeat (8) step(0, '0, 3'd3, '0, 0, 0);
    step(0, '0, 3'd5, 3'b100, 1, 0);
    step(0, '0, 3'd5, 3'b010, 0, 0);
    repeat (6) step(0, p, 3'd1, '0, 0, 0);
    step(0, p, 3'd0, '0, 0, 0);
    step(1, p, 3'd1, '0, 0, 0);
    for (int seg = 0; seg < 200; seg++) begin
      pick = $urandom_range(0, 19);
      if (pick < 10)      s = 3'd1;
      else if (pick < 13) s = 3'd2;
      else if (pick < 14) s = 3'd0;
      else                s = 3'($urandom_range(3, 7));
      len = $urandom_range(1, 15);
      for (int j = 0; j < len; j++) begin
        step(($urandom_range(0, 199) == 0),
             DW'({$urandom(), $urandom()}), s,
             ($urandom_range(0, 7) == 0) ? NE'($urandom()) : '0,
             ($urandom_range(0, 15) == 0),
             ($urandom_range(0, 7) == 0));
      end
    end
    stim_done = 1;
  endtask

  initial begin
    fork
      stimulus();
      monitor();
    join
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
